ascon_word_fifo: RTL and testbench
==================================

# ascon_word_fifo

Input-side data buffer for the Ascon core: accepts 32-bit words from the subsystem register/bus side, packs word pairs into 64-bit blocks, and serves them through the pop/empty/flush interface the Ascon FSM drives on its AD and PT ports. One instance sits in front of the AD port and one in front of the PT port. The block answers the core's pops, so it is first-word-fall-through: the head block is visible before it is popped.

## Interface

Parameters:
- `Depth`, 8: number of 64-bit entries; power of two, at least 2.
- `PtrWidth`, `$clog2(Depth)`: derived, not overridden.

Ports:
- `clk_i`  in  1  clock.
- `rst_n_i`  in  1  reset; asynchronous, active-low.
- `wr_valid_i`  in  1  bus-side word valid.
- `wr_data_i`  in  32  bus-side word.
- `wr_ready_o`  out  1  word accepted when `wr_valid_i && wr_ready_o`.
- `pop_i`  in  1  core pops the head block.
- `data_o`  out  64  head block; `'0` when empty.
- `empty_o`  out  1  no complete block stored.
- `full_o`  out  1  `Depth` blocks stored.
- `flush_i`  in  1  core-driven clear.
- `level_o`  out  PtrWidth+1  stored block count, 0..Depth.
- `half_o`  out  1  one word of a pair is held.
- `underflow_o`  out  1  sticky; set by a pop while empty.

## Operation

- **Packer states:** two states, `LOW_NEXT` and `HIGH_HELD`. Reset state is `LOW_NEXT`.
- **Accept in `LOW_NEXT`:** the word is latched into the high half (bits 63:32). The state moves to `HIGH_HELD`.
- **Accept in `HIGH_HELD`:** the word becomes bits 31:0. The assembled block is written at the write pointer, and the state returns to `LOW_NEXT`.
- **Word order:** the first word is the most-significant half, matching Ascon big-endian block order.
- **`wr_ready_o`:** equals `!full_o` in both packer states.
- **Pop:** when `pop_i` is high and the FIFO is not empty, the read pointer advances.
- **Pop while empty:** no pointer change. `underflow_o` is set and stays set until flush or reset.
- **Pointers:** `PtrWidth`-bit pointers that wrap modulo `Depth`, plus a `PtrWidth+1`-bit count.
- **Derived flags:** `empty_o` is `count==0`; `full_o` is `count==Depth`.
- **Push and pop in the same cycle** (FIFO non-empty, packer completing a pair): both take effect and the count is unchanged.
- **Flush:** `flush_i` has priority over push and pop in the same cycle. It clears both pointers and the count, returns the packer to `LOW_NEXT`, discards the held half, and clears `underflow_o`. Storage contents are not cleared.
- **Overflow:** not possible, because `wr_ready_o` gates every accept.

## Timing

- **Reset values:** `wr_ready_o`=1, `data_o`=0, `empty_o`=1, `full_o`=0, `level_o`=0, `half_o`=0, `underflow_o`=0.
- **Write latency:** second word accepted at edge N; from N+1, `empty_o`=0, `level_o` has incremented, and `data_o` shows the block if it is the head.
- **Pop latency:** pop at edge N; `data_o` shows the next entry, or 0 if now empty, from N+1.
- **Combinational outputs:** `data_o`, `empty_o`, `full_o` and `wr_ready_o` derive from registers only. There is no combinational path from `pop_i` or `wr_valid_i` to any output.
- **Full boundary:** at `full_o`=1, `wr_ready_o`=0 even when `pop_i` is high in the same cycle. The writer retries the next cycle.
- **Flush timing:** flush at edge N; `empty_o`=1 and `half_o`=0 from N+1. A word presented in the flush cycle is dropped.
- **Asynchronous reset mid-operation:** all state returns to reset values immediately, with no clock needed.

## Structure

- **Shared package:** add to `ascon_pack`:
  - a `packer_state_e` enum (`LOW_NEXT`, `HIGH_HELD`);
  - `BlockWidth`=64 and `WordWidth`=32 constants.
- **Sub-module `word_packer`:** holds the state register, the held high word and the `block_valid` strobe.
- **Top level:** holds the register-array storage, pointers, count and sticky flag.
- **Size:** about 180 lines of RTL.

## Test plan

- **Single block:** reset, then write 0x01234567 and 0x89ABCDEF. Required: `half_o`=1 after the first word, then `data_o`=0x0123456789ABCDEF, `empty_o`=0, `level_o`=1.
- **Fill:** write 2×Depth words. Required: `full_o`=1 and `wr_ready_o`=0. A further word with valid held 3 cycles is not accepted; after one pop it is accepted.
- **Pop and wrap:** pop all Depth blocks, refill Depth more, then pop all again. Required: data emerges in FIFO order across the pointer wrap, and `empty_o`=1 at the end.
- **Simultaneous push and pop:** at `level_o`=3, complete a pair while `pop_i`=1. Required: `level_o` stays 3 and the head advances.
- **Underflow:** pop while empty. Required: `underflow_o`=1 and held; `level_o` stays 0; flush clears `underflow_o`.
- **Flush and reset:** with one word held and 2 blocks stored, assert flush together with a word write. Required: `level_o`=0, `half_o`=0, `empty_o`=1 next cycle. Asserting `rst_n_i` low mid-fill returns all outputs to reset values with no clock.

Source files
------------

// File: rtl/ascon_pack.sv
// rtl/ascon_pack.sv - shared types and widths for the Ascon input buffers
package ascon_pack;

    typedef enum logic {
        LOW_NEXT  = 1'b0,
        HIGH_HELD = 1'b1
    } packer_state_e;

    localparam int BlockWidth = 64;
    localparam int WordWidth  = 32;

endpackage

// File: rtl/ascon_word_fifo_if.sv
// rtl/ascon_word_fifo_if.sv - bus-side word writes and core-side block pops
interface ascon_word_fifo_if
    import ascon_pack::*;
#(
    parameter int Depth = 8
);
    logic                   wr_valid_i;
    logic [WordWidth-1:0]   wr_data_i;
    logic                   wr_ready_o;
    logic                   pop_i;
    logic [BlockWidth-1:0]  data_o;
    logic                   empty_o;
    logic                   full_o;
    logic                   flush_i;
    logic [$clog2(Depth):0] level_o;
    logic                   half_o;
    logic                   underflow_o;

    modport master (
        output wr_valid_i, wr_data_i, pop_i, flush_i,
        input  wr_ready_o, data_o, empty_o, full_o, level_o, half_o, underflow_o
    );

    modport slave (
        input  wr_valid_i, wr_data_i, pop_i, flush_i,
        output wr_ready_o, data_o, empty_o, full_o, level_o, half_o, underflow_o
    );
endinterface

// File: rtl/ascon_word_fifo_packer.sv
// rtl/ascon_word_fifo_packer.sv - pairs 32-bit words into big-endian 64-bit blocks
module word_packer
    import ascon_pack::*;
(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  accept_i,
    input  logic                  flush_i,
    input  logic [WordWidth-1:0]  word_i,
    output logic                  half_o,
    output logic                  block_valid_o,
    output logic [BlockWidth-1:0] block_o
);
    packer_state_e        state_q;
    logic [WordWidth-1:0] high_q;

    // The pair completes in the same cycle the second word is accepted so the
    // block lands in storage on that edge.
    assign block_valid_o = accept_i && (state_q == HIGH_HELD);
    assign block_o       = {high_q, word_i};
    assign half_o        = (state_q == HIGH_HELD);

    // Packer FSM: first word goes high, second word closes the pair.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= LOW_NEXT;
            high_q  <= '0;
        end else if (flush_i) begin
            state_q <= LOW_NEXT;
            high_q  <= '0;
        end else if (accept_i) begin
            case (state_q)
                LOW_NEXT: begin
                    high_q  <= word_i;
                    state_q <= HIGH_HELD;
                end
                HIGH_HELD: begin
                    state_q <= LOW_NEXT;
                end
                default: state_q <= LOW_NEXT;
            endcase
        end
    end
endmodule

// File: rtl/ascon_word_fifo.sv
// rtl/ascon_word_fifo.sv - first-word-fall-through block FIFO in front of an Ascon data port
module ascon_word_fifo
    import ascon_pack::*;
#(
    parameter int Depth    = 8,
    parameter int PtrWidth = $clog2(Depth)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    ascon_word_fifo_if.slave         bus
);
    localparam logic [PtrWidth:0] FullCount = (PtrWidth + 1)'(Depth);

    logic [BlockWidth-1:0] mem [Depth];
    logic [PtrWidth-1:0]   wr_ptr_q;
    logic [PtrWidth-1:0]   rd_ptr_q;
    logic [PtrWidth:0]     count_q;
    logic                  underflow_q;

    logic                  empty;
    logic                  full;
    logic                  accept;
    logic                  push;
    logic                  pop_ok;
    logic [BlockWidth-1:0] block;

    assign empty  = (count_q == '0);
    assign full   = (count_q == FullCount);
    // Flush drops any word presented alongside it.
    assign accept = bus.wr_valid_i && !full && !bus.flush_i;
    assign pop_ok = bus.pop_i && !empty;

    word_packer u_packer (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .accept_i      (accept),
        .flush_i       (bus.flush_i),
        .word_i        (bus.wr_data_i),
        .half_o        (bus.half_o),
        .block_valid_o (push),
        .block_o       (block)
    );

    assign bus.wr_ready_o  = !full;
    assign bus.empty_o     = empty;
    assign bus.full_o      = full;
    assign bus.level_o     = count_q;
    assign bus.underflow_o = underflow_q;
    assign bus.data_o      = empty ? '0 : mem[rd_ptr_q];

    // Block storage; contents survive flush and reset, only pointers move.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= block;
        end
    end

    // Pointers, occupancy and sticky underflow; flush wins over push and pop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else if (bus.flush_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrWidth'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
            end
            if (push && !pop_ok) begin
                count_q <= count_q + (PtrWidth + 1)'(1);
            end else if (pop_ok && !push) begin
                count_q <= count_q - (PtrWidth + 1)'(1);
            end
            if (bus.pop_i && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ascon_word_fifo.sv
// tb/tb_ascon_word_fifo.sv - self-checking bench for ascon_word_fifo
module tb_ascon_word_fifo;
    localparam int Depth = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ascon_word_fifo_if #(.Depth(Depth)) bus ();

    ascon_word_fifo #(.Depth(Depth)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of complete blocks plus the pending high word.
    logic [63:0] mq[$];
    logic        m_half;
    logic [31:0] m_high;
    logic        m_uf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_half = 1'b0;
            m_high = '0;
            m_uf   = 1'b0;
        end else if (bus.flush_i) begin
            mq.delete();
            m_half = 1'b0;
            m_high = '0;
            m_uf   = 1'b0;
        end else begin
            automatic bit acc = bus.wr_valid_i && (mq.size() < Depth);
            if (bus.pop_i) begin
                if (mq.size() == 0) m_uf = 1'b1;
                else void'(mq.pop_front());
            end
            if (acc) begin
                if (!m_half) begin
                    m_high = bus.wr_data_i;
                    m_half = 1'b1;
                end else begin
                    mq.push_back({m_high, bus.wr_data_i});
                    m_half = 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_data",  bus.data_o, (mq.size() > 0) ? mq[0] : 64'd0);
        chk("m_empty", 64'(bus.empty_o), 64'(mq.size() == 0));
        chk("m_full",  64'(bus.full_o), 64'(mq.size() == Depth));
        chk("m_ready", 64'(bus.wr_ready_o), 64'(mq.size() != Depth));
        chk("m_level", 64'(bus.level_o), 64'(mq.size()));
        chk("m_half",  64'(bus.half_o), 64'(m_half));
        chk("m_uf",    64'(bus.underflow_o), 64'(m_uf));
    end

    task automatic write_word(input logic [31:0] w);
        bit done = 1'b0;
        @(negedge clk); #1;
        bus.wr_valid_i = 1'b1;
        bus.wr_data_i  = w;
        for (int i = 0; i < 40; i++) begin
            automatic logic r = bus.wr_ready_o;
            @(posedge clk);
            if (r) begin
                done = 1'b1;
                break;
            end
        end
        #1;
        bus.wr_valid_i = 1'b0;
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL write_timeout: got not-accepted expected accepted for %h", w);
        end
    endtask

    task automatic pop_one();
        @(negedge clk); #1;
        bus.pop_i = 1'b1;
        @(posedge clk); #1;
        bus.pop_i = 1'b0;
    endtask

    task automatic flush_one();
        @(negedge clk); #1;
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ready"}, 64'(bus.wr_ready_o), 64'd1);
        chk({tag, "_data"},  bus.data_o, 64'd0);
        chk({tag, "_empty"}, 64'(bus.empty_o), 64'd1);
        chk({tag, "_full"},  64'(bus.full_o), 64'd0);
        chk({tag, "_level"}, 64'(bus.level_o), 64'd0);
        chk({tag, "_half"},  64'(bus.half_o), 64'd0);
        chk({tag, "_uf"},    64'(bus.underflow_o), 64'd0);
    endtask

    initial begin
        bus.wr_valid_i = 1'b0;
        bus.wr_data_i  = '0;
        bus.pop_i      = 1'b0;
        bus.flush_i    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Single block, big-endian word order
        write_word(32'h01234567);
        chk("single_half", 64'(bus.half_o), 64'd1);
        write_word(32'h89ABCDEF);
        chk("single_data",  bus.data_o, 64'h0123456789ABCDEF);
        chk("single_empty", 64'(bus.empty_o), 64'd0);
        chk("single_level", 64'(bus.level_o), 64'd1);
        pop_one();
        chk("single_popped", 64'(bus.empty_o), 64'd1);

        // Fill to full, then a writer stalls until one pop frees space
        for (int i = 0; i < 2 * Depth; i++) write_word(32'h10000000 + 32'(i));
        chk("fill_full",  64'(bus.full_o), 64'd1);
        chk("fill_ready", 64'(bus.wr_ready_o), 64'd0);
        @(negedge clk); #1;
        bus.wr_valid_i = 1'b1;
        bus.wr_data_i  = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_level", 64'(bus.level_o), 64'd8);
        chk("stall_half",  64'(bus.half_o), 64'd0);
        @(negedge clk); #1;
        bus.pop_i = 1'b1;
        @(posedge clk); #1;
        bus.pop_i = 1'b0;
        @(posedge clk); #1;
        bus.wr_valid_i = 1'b0;
        chk("retry_half",  64'(bus.half_o), 64'd1);
        chk("retry_level", 64'(bus.level_o), 64'd7);
        chk("retry_head",  bus.data_o, 64'h1000000210000003);
        write_word(32'h0BADF00D);

        // Drain, refill across the pointer wrap, drain again
        for (int i = 0; i < Depth; i++) pop_one();
        chk("drain_empty", 64'(bus.empty_o), 64'd1);
        for (int i = 16; i < 32; i++) write_word(32'h10000000 + 32'(i));
        chk("refill_full", 64'(bus.full_o), 64'd1);
        for (int i = 0; i < Depth - 1; i++) pop_one();
        chk("wrap_last", bus.data_o, 64'h1000001E1000001F);
        pop_one();
        chk("wrap_empty", 64'(bus.empty_o), 64'd1);

        // Pair completes on the same edge as a pop
        for (int i = 0; i < 7; i++) write_word(32'hA0000000 + 32'(i));
        chk("pp_level_before", 64'(bus.level_o), 64'd3);
        @(negedge clk); #1;
        bus.wr_valid_i = 1'b1;
        bus.wr_data_i  = 32'hA0000007;
        bus.pop_i      = 1'b1;
        @(posedge clk); #1;
        bus.wr_valid_i = 1'b0;
        bus.pop_i      = 1'b0;
        chk("pp_level", 64'(bus.level_o), 64'd3);
        chk("pp_head",  bus.data_o, 64'hA0000002A0000003);

        // Flush with a held word, two blocks stored and a word in the flush cycle
        pop_one();
        write_word(32'hA0000008);
        chk("fl_pre_level", 64'(bus.level_o), 64'd2);
        chk("fl_pre_half",  64'(bus.half_o), 64'd1);
        @(negedge clk); #1;
        bus.flush_i    = 1'b1;
        bus.wr_valid_i = 1'b1;
        bus.wr_data_i  = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus.flush_i    = 1'b0;
        bus.wr_valid_i = 1'b0;
        chk("fl_level", 64'(bus.level_o), 64'd0);
        chk("fl_half",  64'(bus.half_o), 64'd0);
        chk("fl_empty", 64'(bus.empty_o), 64'd1);

        // Underflow is sticky until flush
        pop_one();
        chk("uf_set", 64'(bus.underflow_o), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("uf_hold",  64'(bus.underflow_o), 64'd1);
        chk("uf_level", 64'(bus.level_o), 64'd0);
        flush_one();
        chk("uf_clear", 64'(bus.underflow_o), 64'd0);

        // Asynchronous reset mid-fill, checked between clock edges
        for (int i = 0; i < 3; i++) write_word(32'hC0000000 + 32'(i));
        chk("ar_pre_level", 64'(bus.level_o), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_values("arst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
